// File: rtl/ram_load_sequencer.sv
// ROM-to-RAM block copier: one FETCH/WRITE pair per word, stalls while wr_allow is low.
// A job is started from IDLE and can be cancelled by abort.
module ram_load_sequencer #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] src_base,
  input  logic [ADDR_WIDTH-1:0] dst_base,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic                  wr_allow,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {StIdle, StFetch, StWrite, StDone} state_e;

  localparam logic [ADDR_WIDTH:0] IdxOne = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   idx_q, len_q;
  logic [ADDR_WIDTH-1:0] src_q, dst_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  last_word;

  // Index is one bit wider than the address so a full 2^ADDR_WIDTH job terminates.
  assign last_word = (idx_q + IdxOne) == len_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d = (len == '0) ? StDone : StFetch;
        end
      end
      StFetch: state_d = abort ? StIdle : StWrite;
      StWrite: begin
        if (abort) begin
          state_d = StIdle;
        end else if (wr_allow) begin
          state_d = last_word ? StDone : StFetch;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      len_q  <= '0;
      src_q  <= '0;
      dst_q  <= '0;
      data_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && !abort) begin
            src_q <= src_base;
            dst_q <= dst_base;
            len_q <= len;
            idx_q <= '0;
          end
        end
        StFetch: begin
          if (!abort) begin
            data_q <= rom_data;
          end
        end
        StWrite: begin
          if (wr_allow && !abort) begin
            idx_q <= idx_q + IdxOne;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rom_addr  = src_q + idx_q[ADDR_WIDTH-1:0];
    ram_addr  = dst_q + idx_q[ADDR_WIDTH-1:0];
    ram_wdata = data_q;
    busy      = (state_q == StFetch) || (state_q == StWrite);
    done      = (state_q == StDone) && !abort;
    ram_we    = (state_q == StWrite) && wr_allow && !abort;
  end

endmodule

// File: tb/tb_ram_load_sequencer.sv
// Scoreboard bench for ram_load_sequencer: expected RAM writes are queued when a job
// starts and matched against every ram_we cycle.
module tb_ram_load_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [7:0]  src_base;
  logic [7:0]  dst_base;
  logic [8:0]  len;
  logic        wr_allow;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        busy;
  logic        done;

  ram_load_sequencer #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(32)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .src_base (src_base),
    .dst_base (dst_base),
    .len      (len),
    .wr_allow (wr_allow),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [7:0] a);
    logic [7:0] sw;
    sw = {a[3:0], a[7:4]};
    return {a ^ 8'h5A, ~a, a + 8'd17, sw ^ 8'hC3};
  endfunction

  assign rom_data = rom_word(rom_addr);

  logic [31:0] ram [256];
  always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_wdata;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_cnt = 0;
  int t_start = 0;
  int we_cnt  = 0;
  int done_cnt = 0;
  int busy_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (busy) busy_cnt++;
      if (ram_we) begin
        exp_t e;
        we_cnt++;
        if (exp_q.size() == 0) begin
          check("we_unexpected", 64'(ram_we), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 64'(ram_addr), 64'(e.addr));
          check("wr_data", 64'(ram_wdata), 64'(e.data));
        end
      end
    end
  end

  // Start edge is sampled inside; returns 1ns after it, in the first job cycle.
  task automatic start_job(input logic [7:0] src, input logic [7:0] dst, input logic [8:0] n,
                           input int n_push);
    @(posedge clk); #1;
    start    = 1'b1;
    src_base = src;
    dst_base = dst;
    len      = n;
    for (int i = 0; i < n_push; i++) begin
      exp_t e;
      e.addr = dst + 8'(i);
      e.data = rom_word(src + 8'(i));
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    t_start  = cyc_cnt;
    start    = 1'b0;
    src_base = 8'($urandom);
    dst_base = 8'($urandom);
    len      = 9'($urandom);
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int lat;
    int guard;
    lat   = -1;
    guard = 0;
    while (guard < 2000) begin
      @(negedge clk);
      guard++;
      if (done) begin
        lat = cyc_cnt - t_start + 1;
        break;
      end
    end
    check(tag, 64'(lat), 64'(exp_lat));
    @(negedge clk);
    check({tag, "_done_1cyc"}, 64'(done), 64'd0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int we0, done0, busy0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; wr_allow = 1'b1;
    src_base = '0; dst_base = '0; len = '0;
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_we", 64'(ram_we), 64'd0);
    check("rst_rom_addr", 64'(rom_addr), 64'd0);
    check("rst_ram_addr", 64'(ram_addr), 64'd0);
    check("rst_wdata", 64'(ram_wdata), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic 4-word copy
    we0 = we_cnt;
    start_job(8'h10, 8'h80, 9'd4, 4);
    wait_done("basic_lat", 9);
    check("basic_we_cnt", 64'(we_cnt - we0), 64'd4);
    for (int i = 0; i < 4; i++) check("basic_ram", 64'(ram[8'h80 + i]), 64'(rom_word(8'h10 + 8'(i))));

    // Zero-length job
    we0 = we_cnt; busy0 = busy_cnt;
    start_job(8'h33, 8'h44, 9'd0, 0);
    wait_done("len0_lat", 1);
    check("len0_we_cnt", 64'(we_cnt - we0), 64'd0);
    check("len0_busy", 64'(busy_cnt - busy0), 64'd0);

    // Address wrap
    start_job(8'hFE, 8'hFF, 9'd3, 3);
    wait_done("wrap_lat", 7);
    check("wrap_ram_ff", 64'(ram[8'hFF]), 64'(rom_word(8'hFE)));
    check("wrap_ram_00", 64'(ram[8'h00]), 64'(rom_word(8'hFF)));
    check("wrap_ram_01", 64'(ram[8'h01]), 64'(rom_word(8'h00)));

    // Stall 5 cycles in the first WRITE
    start_job(8'h20, 8'h40, 9'd2, 2);
    @(posedge clk); #1;
    wr_allow = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_we", 64'(ram_we), 64'd0);
      check("stall_addr", 64'(ram_addr), 64'h40);
      check("stall_data", 64'(ram_wdata), 64'(rom_word(8'h20)));
      if (i < 4) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    wr_allow = 1'b1;
    wait_done("stall_lat", 10);

    // Abort in 3rd WRITE of an 8-word job
    we0 = we_cnt; done0 = done_cnt;
    start_job(8'h30, 8'h50, 9'd8, 2);
    repeat (5) begin
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(negedge clk);
    check("abort_we", 64'(ram_we), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_idle_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    check("abort_we_cnt", 64'(we_cnt - we0), 64'd2);
    check("abort_no_done", 64'(done_cnt - done0), 64'd0);
    check("abort_q_empty", 64'(exp_q.size()), 64'd0);
    start_job(8'h00, 8'h90, 9'd3, 3);
    wait_done("post_abort_lat", 7);

    // abort + start together in IDLE
    done0 = done_cnt; busy0 = busy_cnt;
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; len = 9'd4;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_start_busy", 64'(busy_cnt - busy0), 64'd0);
    check("abort_start_done", 64'(done_cnt - done0), 64'd0);

    // Asynchronous reset mid-job, then a full 256-word job
    we0 = we_cnt;
    start_job(8'h05, 8'h60, 9'd6, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_we", 64'(ram_we), 64'd0);
    check("arst_rom_addr", 64'(rom_addr), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("arst_busy_idle", 64'(busy), 64'd0);
    check("arst_we_cnt", 64'(we_cnt - we0), 64'd1);
    check("arst_q_empty", 64'(exp_q.size()), 64'd0);
    we0 = we_cnt;
    start_job(8'h00, 8'h00, 9'd256, 256);
    wait_done("full_lat", 513);
    check("full_we_cnt", 64'(we_cnt - we0), 64'd256);
    check("full_q_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_load_sequencer.md
RAM_LOAD_SEQUENCER -- requirements
Module: ram_load_sequencer

Interface
REQ-001: Parameter ADDR_WIDTH, default 8, SHALL set the ROM/RAM word-address width.
REQ-002: Parameter DATA_WIDTH, default 32, SHALL set the word width.
REQ-003: clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004: rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005: start  input  1  SHALL request one copy job when high in IDLE.
REQ-006: abort  input  1  SHALL cancel the running job.
REQ-007: src_base  input  ADDR_WIDTH  SHALL give the first ROM address, sampled with start.
REQ-008: dst_base  input  ADDR_WIDTH  SHALL give the first RAM address, sampled with start.
REQ-009: len  input  ADDR_WIDTH+1  SHALL give the word count (0..2^ADDR_WIDTH), sampled with start.
REQ-010: wr_allow  input  1  SHALL permit RAM writes when high (low during display read windows).
REQ-011: rom_addr  output  ADDR_WIDTH  SHALL drive the ROM read address; the ROM is combinational.
REQ-012: rom_data  input  DATA_WIDTH  SHALL be the ROM read data for rom_addr, same cycle.
REQ-013: ram_we  output  1  SHALL be the RAM write enable; the write commits on the rising edge.
REQ-014: ram_addr  output  ADDR_WIDTH  SHALL drive the RAM write address.
REQ-015: ram_wdata  output  DATA_WIDTH  SHALL drive the RAM write data.
REQ-016: busy  output  1  SHALL be high in states FETCH and WRITE.
REQ-017: done  output  1  SHALL be a one-cycle pulse on job completion.

Function
REQ-018: States SHALL be IDLE, FETCH, WRITE and DONE.
REQ-019: In IDLE with start=1, the block SHALL latch src_base, dst_base and len and clear the word index.
- Next state SHALL be FETCH if len>0.
- Next state SHALL be DONE if len=0.
REQ-020: FETCH SHALL last exactly one cycle.
- rom_addr SHALL equal src_q+index.
- rom_data SHALL be registered into data_q.
- Next state SHALL be WRITE.
REQ-021: In WRITE, ram_we SHALL equal wr_allow combinationally.
- ram_addr SHALL equal dst_q+index.
- ram_wdata SHALL equal data_q.
REQ-022: In WRITE with wr_allow=0, the state SHALL hold with index, data_q and addresses unchanged (stall).
REQ-023: In WRITE with wr_allow=1, the index SHALL increment.
- Next state SHALL be DONE if index+1 equals len_q.
- Otherwise next state SHALL be FETCH.
REQ-024: DONE SHALL assert done for one cycle and then return to IDLE.
REQ-025: Address sums SHALL wrap modulo 2^ADDR_WIDTH.
REQ-026: The index counter SHALL be ADDR_WIDTH+1 bits wide so that len=2^ADDR_WIDTH completes.
REQ-027: With wr_allow held high, a job of N>0 words SHALL take 2N cycles from the start-sampling edge to DONE entry, then 1 DONE cycle.
REQ-028: start SHALL be ignored outside IDLE; base and len changes during a job SHALL have no effect.
REQ-029: abort=1 in FETCH, WRITE or DONE SHALL force IDLE at the next edge.
- No done pulse SHALL be produced.
- ram_we SHALL be forced 0 in the abort cycle.
- Any partial RAM contents SHALL remain.
REQ-030: abort and start both high in IDLE: abort SHALL win and the block SHALL stay in IDLE.
REQ-031: ram_we SHALL be 0 in every state except WRITE.

Reset
REQ-032: rst_n=0 SHALL immediately force IDLE and set index, data_q, src_q, dst_q and len_q to 0.
- Outputs SHALL be busy=0, done=0, ram_we=0, rom_addr=0, ram_addr=0, ram_wdata=0.
REQ-033: Reset asserted mid-job SHALL take effect asynchronously.
- No further writes SHALL occur.
- After release, the block SHALL wait in IDLE for a new start.

Verification
REQ-034: src=0x10, dst=0x80, len=4, wr_allow=1 -> RAM[0x80..0x83]=ROM[0x10..0x13]; done at cycle 9 after start; 4 ram_we pulses.
REQ-035: len=0 -> no ram_we; busy stays 0; done pulses the cycle after start.
REQ-036: src=0xFE, dst=0xFF, len=3 -> writes ROM[0xFE]->RAM[0xFF], ROM[0xFF]->RAM[0x00], ROM[0x00]->RAM[0x01].
REQ-037: len=2, wr_allow low for 5 cycles during the first WRITE -> ram_we stays 0 for those cycles; addr/data hold; done is delayed by exactly 5 cycles.
REQ-038: abort in the 3rd WRITE of len=8 -> exactly 2 words written, no done, IDLE next cycle; a new start then runs normally.
REQ-039: rst_n pulsed low mid-job (between edges) -> busy and ram_we drop immediately; len=256 after reset copies all 256 words, then done.
